// File: rtl/sram_like_slave_pkg.sv
// Shared types and helpers for the SRAM-like responder: size encodings,
// pending-entry width and the byte-strobe merge used on writes.
package sram_like_slave_pkg;

    typedef enum logic [1:0] {
        SRAM_SIZE_BYTE = 2'd0,
        SRAM_SIZE_HALF = 2'd1,
        SRAM_SIZE_WORD = 2'd2
    } sram_size_e;

    localparam int SLAVE_DATA_WD = 32;

    // Pending entry layout: {is_wr, data[31:0], cnt[cnt_w-1:0]}
    function automatic int slave_entry_wd(input int cnt_w);
        return 1 + SLAVE_DATA_WD + cnt_w;
    endfunction

    function automatic logic [31:0] strb_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/sram_like_slave_pend_fifo.sv
// In-order pending-transaction queue with per-entry latency countdowns.
// Exposes the entry that will be at the head after this edge's pop.
module sram_like_pend_fifo
    import sram_like_slave_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push_i,
    input  logic             push_wr_i,
    input  logic [31:0]      push_data_i,
    input  logic [CNT_W-1:0] push_cnt_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             up_rdy_o,
    output logic             up_wr_o,
    output logic [31:0]      up_data_o
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int EW = slave_entry_wd(CNT_W);

    logic [MAX_OUTSTANDING-1:0][EW-1:0] ent_q, ent_d;
    logic [MAX_OUTSTANDING-1:0]         vld_q, vld_d;
    logic [PW-1:0]                      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]                        count_q, count_d;
    logic [PW-1:0]                      up_ptr;

    assign full_o = (count_q == (PW+1)'(MAX_OUTSTANDING));

    // The popped head leaves at this edge, so look one slot ahead to keep
    // back-to-back completions without a bubble.
    assign up_ptr    = pop_i ? rptr_q + 1'b1 : rptr_q;
    assign up_rdy_o  = vld_q[up_ptr] & (ent_q[up_ptr][CNT_W-1:0] == '0);
    assign up_wr_o   = ent_q[up_ptr][EW-1];
    assign up_data_o = ent_q[up_ptr][EW-2:CNT_W];

    always_comb begin
        ent_d   = ent_q;
        vld_d   = vld_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        for (int i = 0; i < MAX_OUTSTANDING; i++)
            if (vld_q[i] && ent_q[i][CNT_W-1:0] != '0)
                ent_d[i][CNT_W-1:0] = ent_q[i][CNT_W-1:0] - 1'b1;
        if (pop_i) begin
            vld_d[rptr_q] = 1'b0;
            rptr_d        = rptr_q + 1'b1;
        end
        if (push_i) begin
            vld_d[wptr_q] = 1'b1;
            ent_d[wptr_q] = {push_wr_i, push_data_i, push_cnt_i};
            wptr_d        = wptr_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ent_q   <= '0;
            vld_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            vld_q   <= vld_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sram_like_slave.sv
// SRAM-like req/addr_ok/data_ok responder over a word-addressed memory.
// Define RANDOM_DELAY_EN for LFSR-driven extra latency and addr_ok stalls.
module sram_like_slave
    import sram_like_slave_pkg::*;
#(
    parameter int DEPTH_LOG2      = 12,
    parameter int MAX_OUTSTANDING = 4,
    parameter int LATENCY         = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  wstrb,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);
    // Countdown must hold LATENCY-1 plus up to 3 random extra cycles.
    localparam int CNT_W = $clog2(LATENCY + 3);

    logic [31:0]           mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           rd_word;
    logic                  accept, full, stall;
    logic [1:0]            extra;
    logic [CNT_W-1:0]      push_cnt;
    logic                  up_rdy, up_wr;
    logic [31:0]           up_data;
    logic                  data_ok_q, data_ok_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  unused_addr;

`ifdef RANDOM_DELAY_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr_q <= 16'hACE1;
        else         lfsr_q <= lfsr_d;
    end
    assign extra = lfsr_q[1:0];
    assign stall = (lfsr_q[3:2] == 2'b00);
`else
    assign extra = 2'b00;
    assign stall = 1'b0;
`endif

    assign unused_addr = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};
    assign idx         = addr[DEPTH_LOG2+1:2];
    assign addr_ok     = resetn & ~full & ~stall;
    assign accept      = req & addr_ok;
    assign rd_word     = mem[idx];
    assign push_cnt    = CNT_W'(LATENCY - 1) + CNT_W'(extra);

    always_ff @(posedge clk) begin
        if (accept && wr) mem[idx] <= strb_merge(mem[idx], wdata, wstrb);
    end

    sram_like_pend_fifo #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_pend (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (accept),
        .push_wr_i   (wr),
        .push_data_i (rd_word),
        .push_cnt_i  (push_cnt),
        .pop_i       (data_ok_q),
        .full_o      (full),
        .up_rdy_o    (up_rdy),
        .up_wr_o     (up_wr),
        .up_data_o   (up_data)
    );

    // The head is retired at the edge that ends its data_ok cycle.
    always_comb begin
        data_ok_d = up_rdy;
        rdata_d   = '0;
        if (up_rdy && !up_wr) rdata_d = up_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
        end
    end

    assign data_ok = data_ok_q;
    assign rdata   = rdata_q;

`ifndef SYNTHESIS
    word_write_full_strb: assert property (@(posedge clk) disable iff (!resetn)
        (req && wr && size == SRAM_SIZE_WORD) |-> (wstrb == 4'hf));
`endif

endmodule

// File: tb/tb_sram_like_slave.sv
// Randomized bench for sram_like_slave against an in-order reference model:
// a queue of accepted transactions and a word-array image of memory.
module tb_sram_like_slave;
    localparam int DL   = 12;
    localparam int MAXO = 4;
    localparam int LAT  = 3;
`ifdef RANDOM_DELAY_EN
    localparam int EXTRA = 3;
`else
    localparam int EXTRA = 0;
`endif

    logic        clk = 1'b0, resetn = 1'b0, req = 1'b0, wr = 1'b0;
    logic [3:0]  wstrb = '0;
    logic [1:0]  size = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    sram_like_slave #(.DEPTH_LOG2(DL), .MAX_OUTSTANDING(MAXO), .LATENCY(LAT)) dut (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .wstrb(wstrb), .size(size),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          wr;
        logic [31:0] data;
        int          t;
    } pend_t;

    pend_t       pq[$];
    logic [31:0] ref_mem [0:(1<<DL)-1];
    int          prev_done = -100;
    logic [31:0] last_rd = '0;
    int          checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at each negedge: compares outputs with what the model predicts.
    task automatic observe();
        int          lo, hi, occ;
        logic [31:0] exp_rd;
        exp_rd = '0;
        occ    = pq.size();
`ifdef RANDOM_DELAY_EN
        if (occ >= MAXO) chk("addr_ok_full", addr_ok, 0);
`else
        chk("addr_ok", addr_ok, occ < MAXO);
`endif
        if (occ == 0) begin
            chk("dok_idle", data_ok, 0);
        end else begin
            lo = (pq[0].t + LAT > prev_done + 1) ? pq[0].t + LAT : prev_done + 1;
            hi = (pq[0].t + LAT + EXTRA > prev_done + 1) ? pq[0].t + LAT + EXTRA : prev_done + 1;
            if (data_ok === 1'b1) begin
                chk("dok_window", (cyc >= lo && cyc <= hi), 1);
                if (!pq[0].wr) begin
                    exp_rd  = pq[0].data;
                    last_rd = rdata;
                end
                prev_done = cyc;
                void'(pq.pop_front());
            end else begin
                chk("dok_due", cyc < hi, 1);
            end
        end
        chk("rdata", rdata, exp_rd);
    endtask

    task automatic tick(input bit r, input bit w, input logic [3:0] s, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d, output bit acc);
        pend_t e;
        int    ix;
        @(negedge clk);
        observe();
        req = r; wr = r & w; wstrb = s; size = sz; addr = a; wdata = d;
        acc = r && (addr_ok === 1'b1);
        if (acc) begin
            ix     = int'(a[DL+1:2]);
            e.wr   = w;
            e.t    = cyc + 1;
            e.data = ref_mem[ix];
            if (w)
                for (int b = 0; b < 4; b++)
                    if (s[b]) ref_mem[ix][8*b +: 8] = d[8*b +: 8];
            pq.push_back(e);
        end
    endtask

    task automatic xfer(input bit w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            tick(1'b1, w, s, w ? ((s == 4'hf) ? 2'd2 : 2'd0) : 2'd2, a, d, acc);
            n++;
        end
        chk("accepted", acc, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) tick(1'b0, 1'b0, 4'h0, 2'd0, 32'h0, 32'h0, acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (pq.size() != 0 && n < 80) begin
            idle(1);
            n++;
        end
        chk("drained", pq.size(), 0);
    endtask

    localparam logic [31:0] BASE = 32'h1c00_0000;

    initial begin
        bit          acc;
        int          accepted, iters;
        logic [31:0] u, a;
        logic [3:0]  widx, s;
        bit          r, w;

        #1;
        chk("rst_addr_ok", addr_ok, 0);
        chk("rst_data_ok", data_ok, 0);
        chk("rst_rdata", rdata, 0);
        @(negedge clk);
        resetn = 1'b1;
        idle(4);

        for (int i = 0; i < 16; i++) xfer(1'b1, 4'hf, BASE + 32'(4*i), $urandom());
        drain();

        xfer(1'b1, 4'hf, 32'h1c00_0010, 32'h1234_5678);
        xfer(1'b0, 4'h0, 32'h1c00_0010, 32'h0);
        drain();
        chk("word_readback", last_rd, 32'h1234_5678);

        xfer(1'b1, 4'b1000, 32'h1c00_0010, 32'hAB00_0000);
        xfer(1'b0, 4'h0, 32'h1c00_0010, 32'h0);
        drain();
        chk("byte_merge", last_rd, 32'hAB34_5678);

        for (int i = 0; i < 6; i++) xfer(1'b0, 4'h0, BASE + 32'(4*i), 32'h0);
        drain();
        chk("b2b_last", last_rd, ref_mem[5]);

        for (int i = 0; i < 3; i++) xfer(1'b0, 4'h0, BASE + 32'(4*(8+i)), 32'h0);
        tick(1'b0, 1'b0, 4'h0, 2'd0, 32'h0, 32'h0, acc);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_addr_ok", addr_ok, 0);
        chk("midrst_data_ok", data_ok, 0);
        chk("midrst_rdata", rdata, 0);
        pq.delete();
        prev_done = -100;
        @(negedge clk);
        resetn = 1'b1;
        idle(10);
        xfer(1'b0, 4'h0, 32'h1c00_0010, 32'h0);
        drain();
        chk("mem_kept", last_rd, 32'hAB34_5678);

        accepted = 0;
        iters    = 0;
        while (accepted < 1000 && iters < 6000) begin
            u    = $urandom();
            widx = 4'($urandom_range(15));
            a    = {u[31:14], 8'h00, widx, u[1:0]};
            r    = ($urandom_range(3) != 0);
            w    = $urandom_range(1) == 1;
            s    = 4'($urandom_range(15));
            tick(r, w, s, w ? ((s == 4'hf) ? 2'd2 : 2'(u[2])) : 2'($urandom_range(2)),
                 a, $urandom(), acc);
            if (acc) accepted++;
            iters++;
        end
        chk("random_count", accepted, 1000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_like_slave.md
Name: sram_like_slave

Overview:
- Responder end of the SRAM-like req/addr_ok/data_ok interface that the fetch and memory stages drive as initiators.
- Backed by a word-addressed on-chip memory array.
- Accepts up to MAX_OUTSTANDING transactions and returns data_ok/rdata strictly in order after a programmable latency.
- Used in the exp environments as the inst_sram/data_sram model, so that pipeline stall and cancel logic is exercised under split-transaction timing.

Parameters:
- DEPTH_LOG2, 12, log2 of memory depth in 32-bit words.
- MAX_OUTSTANDING, 4, pending-queue depth (power of 2, >=2).
- LATENCY, 2, minimum cycles from address handshake to data_ok (>=1).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req  in  1  request valid
- wr  in  1  1=write, 0=read
- wstrb  in  4  byte enables for writes
- size  in  2  0=byte, 1=half, 2=word (informational; wstrb governs writes)
- addr  in  32  byte address
- wdata  in  32  write data
- addr_ok  out  1  address handshake accepted this cycle
- data_ok  out  1  oldest pending transaction completes this cycle
- rdata  out  32  read data, valid when data_ok is high for a read

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on resetn. On reset: queue empty, pointers and count = 0, addr_ok = 0, data_ok = 0, rdata = 0. Memory contents are not reset.
- Handshake: addr_ok = resetn & ~full, combinational. It does not depend on req. A transaction is accepted on the posedge where req & addr_ok.
- full: count == MAX_OUTSTANDING. A pop in the same cycle does not unblock acceptance.
- Index: addr[DEPTH_LOG2+1:2]. Upper address bits are ignored. Low bits are ignored; there is no alignment check.
- Write: mem[index] bytes with wstrb[i]=1 are updated from wdata bytes at the accept edge. wstrb=0 is a legal no-op write, and it still produces a data_ok.
- Read: mem[index] is sampled at the accept edge and stored in the entry.
  - A read accepted in the cycle after a write to the same word returns the new data.
  - A read accepted in the same cycle as a write is impossible, because there is one port.
- Entry fields: {is_wr, data[31:0], cnt}. cnt is loaded with LATENCY-1 on accept. Every valid entry with cnt>0 decrements each cycle.
- Completion:
  - data_ok = head valid & head.cnt==0, registered output.
  - rdata = head.data for reads and 0 for writes.
  - The head pops on that cycle.
  - The initiator has no back-pressure; data_ok must be consumed.
- Timing: a transaction accepted at edge T gives data_ok high in the cycle after edge T+LATENCY-1, i.e. LATENCY cycles after acceptance when the queue is otherwise idle.
- Ordering: strictly FIFO. At most one data_ok per cycle. Back-to-back accepts produce back-to-back data_ok.
- Simultaneous accept and pop: count unchanged, both pointers advance. Pointers wrap modulo MAX_OUTSTANDING.
- Reset mid-operation: all pending entries are discarded, and no data_ok is issued for them after reset releases.
- size is carried only for assertions. In simulation, flag wr & size==2 & wstrb!=4'hf as an error.

Optional Feature:
- Macro RANDOM_DELAY_EN.
- When defined:
  - A 16-bit LFSR (seed 16'hACE1 on reset, advances every cycle) adds lfsr[1:0] extra cycles to each entry's initial cnt.
  - addr_ok is additionally forced low when lfsr[3:2]==2'b00.
  - FIFO ordering is kept: a later entry whose cnt expires first waits until it reaches the head.
- When not defined: fixed LATENCY timing, and addr_ok depends only on full.

Decomposition:
- Shared header mycpu.h:
  - SRAM_SIZE_BYTE/HALF/WORD constants.
  - The entry width define SLAVE_ENTRY_WD.
- One natural sub-module: sram_like_pend_fifo, holding the entry storage, the countdowns and the head-ready output.
- The top level holds the memory array, the write/strobe logic and the optional LFSR.

Test Plan:
- Reset then idle:
  - addr_ok = 1, data_ok = 0 throughout, rdata = 0.
  - Assert resetn low mid-cycle: addr_ok drops immediately, no clock needed.
- Write 32'h1234_5678 to addr 0x1c000010, wstrb 4'hf, then read addr 0x1c000010:
  - Two data_ok pulses in order.
  - The second has rdata = 32'h1234_5678.
  - With LATENCY=2, each data_ok comes 2 cycles after its accept.
- Byte write wdata 32'hAB00_0000, wstrb 4'b1000 to a word holding 32'h1234_5678, then read:
  - rdata = 32'hAB34_5678.
- Hold req high with 6 back-to-back reads, MAX_OUTSTANDING=4, LATENCY=3:
  - addr_ok low after the 4th accept, and it re-asserts the cycle after the first pop.
  - 6 data_ok in address order, never 2 in one cycle.
- Accept 3 reads, then pulse resetn low before any data_ok:
  - After release, no data_ok appears within 10 cycles.
  - The next read returns memory contents unchanged by the reset.
- With RANDOM_DELAY_EN, 1000 random reads/writes against a scoreboard model:
  - All responses are in order with correct data.
  - Every data_ok comes at least LATENCY and at most LATENCY+3+queue-wait cycles after accept.
